// File: rtl/code_conv_pkg.sv
// code_conv_pkg
//   Shared definitions for the code converter and the blocks that exchange
//   coded counts with it (encoders, CDC pointer logic).
//   code_mode_t : 2-bit conversion selector
//   MODE_*      : the four conversion modes
package code_conv_pkg;

  typedef logic [1:0] code_mode_t;

  localparam code_mode_t MODE_B2G = 2'b00;  // binary -> Gray
  localparam code_mode_t MODE_G2B = 2'b01;  // Gray -> binary
  localparam code_mode_t MODE_B2X = 2'b10;  // binary -> excess-BIAS
  localparam code_mode_t MODE_X2B = 2'b11;  // excess-BIAS -> binary

endpackage

// File: rtl/code_conv_core.sv
// code_conv_core
//   Purely combinational WIDTH-bit code conversion.
//   d    in   WIDTH  input code word
//   mode in   2      conversion selector (code_mode_t)
//   q    out  WIDTH  converted word
//   wrap out  1      excess arithmetic wrapped modulo 2**WIDTH (0 for Gray modes)
module code_conv_core
  import code_conv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BIAS  = 3
) (
  input  logic [WIDTH-1:0] d,
  input  code_mode_t       mode,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH:0]   BIAS_EXT = (WIDTH+1)'(BIAS);
  localparam logic [WIDTH-1:0] BIAS_W   = WIDTH'(BIAS);

  logic [WIDTH:0]   sum_b2x;
  logic [WIDTH-1:0] diff_x2b;
  logic [WIDTH-1:0] bin_g2b;

  // Carry out of the WIDTH+1-bit add is the wrap indication.
  assign sum_b2x  = {1'b0, d} + BIAS_EXT;
  assign diff_x2b = d - BIAS_W;

  // Gray decode is a prefix XOR running from the MSB downwards.
  always_comb begin
    bin_g2b = '0;
    bin_g2b[WIDTH-1] = d[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_g2b[i] = bin_g2b[i+1] ^ d[i];
    end
  end

  always_comb begin
    q    = '0;
    wrap = 1'b0;
    case (mode)
      MODE_B2G: q = d ^ (d >> 1);
      MODE_G2B: q = bin_g2b;
      MODE_B2X: begin
        q    = sum_b2x[WIDTH-1:0];
        wrap = sum_b2x[WIDTH];
      end
      MODE_X2B: begin
        q    = diff_x2b;
        wrap = (d < BIAS_W);
      end
      default: begin
        q    = '0;
        wrap = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/code_converter_pipe.sv
// code_converter_pipe
//   Two-stage valid/ready pipeline around code_conv_core. One word per cycle
//   while out_ready=1; the mode travels with each word.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data, in_mode      input word and its conversion mode
//   out_valid/out_ready   output handshake
//   out_data, out_mode    converted word and the mode that produced it
//   out_wrap              excess arithmetic wrapped (qualified by out_valid)
module code_converter_pipe
  import code_conv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BIAS  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  code_mode_t       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output code_mode_t       out_mode,
  output logic             out_wrap
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  code_mode_t       s1_mode_q,  s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q,  s2_data_d;
  code_mode_t       s2_mode_q,  s2_mode_d;
  logic             s2_wrap_q,  s2_wrap_d;
  // Keeps in_ready low while in reset; rises on the first edge after release.
  logic             run_q,      run_d;

  logic             adv1, adv2;
  logic [WIDTH-1:0] core_q;
  logic             core_wrap;

  code_conv_core #(.WIDTH(WIDTH), .BIAS(BIAS)) u_core (
    .d    (s1_data_q),
    .mode (s1_mode_q),
    .q    (core_q),
    .wrap (core_wrap)
  );

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1 & run_q;

  always_comb begin
    run_d      = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_mode_d  = s2_mode_q;
    s2_wrap_d  = s2_wrap_q;
    if (adv1) begin
      s1_valid_d = in_valid & in_ready;
      // Payload only loads on a real transfer so idle inputs do not toggle S1.
      if (in_valid & in_ready) begin
        s1_data_d = in_data;
        s1_mode_d = in_mode;
      end
    end
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = core_q;
        s2_mode_d = s1_mode_q;
        s2_wrap_d = core_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= MODE_B2G;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mode_q  <= MODE_B2G;
      s2_wrap_q  <= 1'b0;
    end else begin
      run_q      <= run_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_mode_q  <= s2_mode_d;
      s2_wrap_q  <= s2_wrap_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_mode  = s2_mode_q;
  assign out_wrap  = s2_wrap_q;

endmodule

// File: tb/tb_code_converter_pipe.sv
// tb_code_converter_pipe
//   Bench for code_converter_pipe: a WIDTH=4/BIAS=3 instance (a_*) and a
//   WIDTH=8/BIAS=3 instance (b_*) share clock and reset.
module tb_code_converter_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_out_wrap;
  logic [3:0] a_in_data = '0, a_out_data;
  logic [1:0] a_in_mode = '0, a_out_mode;

  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_out_wrap;
  logic [7:0] b_in_data = '0, b_out_data;
  logic [1:0] b_in_mode = '0, b_out_mode;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  code_converter_pipe #(.WIDTH(4), .BIAS(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_mode(a_out_mode), .out_wrap(a_out_wrap)
  );

  code_converter_pipe #(.WIDTH(8), .BIAS(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_mode(b_out_mode), .out_wrap(b_out_wrap)
  );

  // Reference model from the code definitions: Gray decode by searching for the
  // binary value whose Gray code matches; excess modes by modular arithmetic.
  function automatic void ref_conv(input int w, input int bias, input int d, input int m,
                                   output int q, output bit wr);
    int modv;
    modv = 1 << w;
    q  = 0;
    wr = 1'b0;
    case (m)
      0: q = d ^ (d >> 1);
      1: for (int v = 0; v < modv; v++) if ((v ^ (v >> 1)) == d) q = v;
      2: begin q = (d + bias) % modv; wr = ((d + bias) >= modv); end
      default: begin q = (d - bias + modv) % modv; wr = (d < bias); end
    endcase
  endfunction

  // Send one word to dut_a with out_ready=1; lat = edges from accept to the
  // first edge at which out_valid is asserted (-1 if none).
  task automatic run4(input logic [3:0] d, input logic [1:0] m, output logic [3:0] q,
                      output logic [1:0] om, output logic w, output int lat);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; a_out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10 && !a_in_ready; k++) begin @(negedge clk); #1; end
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    lat = -1; q = '0; om = '0; w = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (a_out_valid) begin
        lat = k; q = a_out_data; om = a_out_mode; w = a_out_wrap;
        break;
      end
    end
  endtask

  task automatic run8(input logic [7:0] d, input logic [1:0] m, output logic [7:0] q,
                      output int lat);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d; b_in_mode = m; b_out_ready = 1'b1;
    #1;
    for (int k = 0; k < 10 && !b_in_ready; k++) begin @(negedge clk); #1; end
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = -1; q = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b_out_valid) begin lat = k; q = b_out_data; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got=%b/%b exp=0", a_in_ready, b_in_ready);
    end
    total++;
    if ({a_out_valid, a_out_data, a_out_mode, a_out_wrap} !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got=%b%h%b%b exp=all zero", a_out_valid, a_out_data, a_out_mode, a_out_wrap);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      bad++; $display("FAIL release_in_ready got=%b/%b exp=1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_gray();
    logic [3:0] q; logic [1:0] om; logic w; int lat;
    run4(4'b1011, 2'b00, q, om, w, lat);
    total++;
    if (q !== 4'b1110 || w !== 1'b0 || om !== 2'b00) begin
      bad++; $display("FAIL b2g_1011 got=%b w=%b m=%b exp=1110 w=0 m=00", q, w, om);
    end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL b2g_latency got=%0d exp=2", lat); end
    run4(4'b1110, 2'b01, q, om, w, lat);
    total++;
    if (q !== 4'b1011 || w !== 1'b0 || om !== 2'b01 || lat !== 2) begin
      bad++; $display("FAIL g2b_1110 got=%b w=%b m=%b lat=%0d exp=1011 w=0 m=01 lat=2", q, w, om, lat);
    end
  endtask

  task automatic test_excess();
    logic [3:0] q; logic [1:0] om; logic w; int lat;
    logic [3:0] din [4]  = '{4'd7, 4'd14, 4'd2, 4'd3};
    logic [1:0] mode [4] = '{2'b10, 2'b10, 2'b11, 2'b11};
    logic [3:0] eq [4]   = '{4'd10, 4'd1, 4'd15, 4'd0};
    logic       ew [4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      run4(din[i], mode[i], q, om, w, lat);
      total++;
      if (q !== eq[i] || w !== ew[i] || om !== mode[i] || lat !== 2) begin
        bad++;
        $display("FAIL excess_%0d got=%0d w=%b m=%b lat=%0d exp=%0d w=%b", i, q, w, om, lat, eq[i], ew[i]);
      end
    end
  endtask

  task automatic test_width8();
    logic [7:0] g, b; int lat1, lat2; int eg; bit ew;
    run8(8'hFF, 2'b01, b, lat1);
    total++;
    if (b !== 8'hAA || lat1 !== 2) begin
      bad++; $display("FAIL w8_g2b_ff got=%h lat=%0d exp=aa lat=2", b, lat1);
    end
    for (int v = 0; v < 256; v++) begin
      run8(8'(v), 2'b00, g, lat1);
      run8(g, 2'b01, b, lat2);
      ref_conv(8, 3, v, 0, eg, ew);
      total++;
      if (b !== 8'(v) || g !== 8'(eg) || lat1 !== 2 || lat2 !== 2) begin
        bad++; $display("FAIL w8_roundtrip v=%h gray=%h back=%h exp gray=%h back=%h", v, g, b, eg, v);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] expq [$];
    logic [6:0] snap;
    int sent = 0, got = 0, first_c = -1, last_c = -1;
    int q; bit w;
    a_out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a_in_valid = (sent < 5);
      a_in_data  = 4'($urandom);
      a_in_mode  = (sent % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      if (c == 3) snap = {a_out_wrap, a_out_mode, a_out_data};
      if (a_in_valid && a_in_ready) begin
        ref_conv(4, 3, int'(a_in_data), int'(a_in_mode), q, w);
        expq.push_back({w, a_in_mode, 4'(q)});
        sent++;
      end
    end
    total++;
    if (sent !== 2 || a_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_accepts got=%0d in_ready=%b exp=2 in_ready=0", sent, a_in_ready);
    end
    total++;
    if ({a_out_wrap, a_out_mode, a_out_data} !== snap || a_out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_stable got=%h valid=%b exp=%h valid=1", {a_out_wrap, a_out_mode, a_out_data}, a_out_valid, snap);
    end
    a_out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (c > 0) @(negedge clk);
      a_in_valid = (sent < 5);
      a_in_data  = 4'($urandom);
      a_in_mode  = (sent % 2 == 1) ? 2'b10 : 2'b00;
      #1;
      if (a_out_valid && a_out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL bp_extra got=%h exp=none", a_out_data);
        end else begin
          if ({a_out_wrap, a_out_mode, a_out_data} !== expq[0]) begin
            bad++; $display("FAIL bp_order got=%h exp=%h", {a_out_wrap, a_out_mode, a_out_data}, expq[0]);
          end
          void'(expq.pop_front());
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        ref_conv(4, 3, int'(a_in_data), int'(a_in_mode), q, w);
        expq.push_back({w, a_in_mode, 4'(q)});
        sent++;
      end
    end
    a_in_valid = 1'b0;
    total++;
    if (got !== 5 || last_c - first_c !== 4) begin
      bad++; $display("FAIL bp_drain got=%0d span=%0d exp=5 span=4", got, last_c - first_c);
    end
  endtask

  task automatic test_random();
    logic [6:0] expq [$];
    logic [6:0] held = '0;
    bit stalled = 1'b0;
    int q; bit w;
    int xfers = 0;
    for (int c = 0; c < 10020; c++) begin
      @(negedge clk);
      if (c < 10000) begin
        a_in_valid  = 1'($urandom);
        a_out_ready = 1'($urandom);
      end else begin
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
      end
      a_in_data = 4'($urandom);
      a_in_mode = 2'($urandom);
      #1;
      if (stalled) begin
        total++;
        if (a_out_valid !== 1'b1 || {a_out_wrap, a_out_mode, a_out_data} !== held) begin
          bad++; $display("FAIL rnd_stall got=%h valid=%b exp=%h", {a_out_wrap, a_out_mode, a_out_data}, a_out_valid, held);
        end
      end
      if (a_out_valid && a_out_ready) begin
        total++;
        xfers++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL rnd_dup got=%h exp=none", {a_out_wrap, a_out_mode, a_out_data});
        end else begin
          if ({a_out_wrap, a_out_mode, a_out_data} !== expq[0]) begin
            bad++; $display("FAIL rnd_data got=%h exp=%h", {a_out_wrap, a_out_mode, a_out_data}, expq[0]);
          end
          void'(expq.pop_front());
        end
      end
      stalled = a_out_valid && !a_out_ready;
      held    = {a_out_wrap, a_out_mode, a_out_data};
      if (a_in_valid && a_in_ready) begin
        ref_conv(4, 3, int'(a_in_data), int'(a_in_mode), q, w);
        expq.push_back({w, a_in_mode, 4'(q)});
      end
    end
    total++;
    if (expq.size() != 0 || xfers < 1000) begin
      bad++; $display("FAIL rnd_drops left=%0d xfers=%0d exp left=0", expq.size(), xfers);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] q; logic [1:0] om; logic w; int lat;
    int stale = 0;
    a_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = 4'(i + 5); a_in_mode = 2'b10;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async valid=%b in_ready=%b exp=0/0", a_out_valid, a_in_ready);
    end
    @(negedge clk); #1;
    total++;
    if (a_in_ready !== 1'b0 || {a_out_data, a_out_mode, a_out_wrap} !== 7'h00) begin
      bad++; $display("FAIL rst_mid_hold in_ready=%b out=%h exp=0/0", a_in_ready, {a_out_data, a_out_mode, a_out_wrap});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (a_out_valid) stale++;
      if (c == 0) begin
        total++;
        if (a_in_ready !== 1'b1) begin
          bad++; $display("FAIL rst_mid_ready got=%b exp=1", a_in_ready);
        end
      end
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL rst_mid_stale got=%0d exp=0", stale); end
    run4(4'd9, 2'b10, q, om, w, lat);
    total++;
    if (q !== 4'd12 || w !== 1'b0 || om !== 2'b10 || lat !== 2) begin
      bad++; $display("FAIL rst_mid_next got=%0d w=%b m=%b lat=%0d exp=12 w=0 m=10 lat=2", q, w, om, lat);
    end
  endtask

  initial begin
    test_reset();
    test_gray();
    test_excess();
    test_width8();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
